conv_window_scheduler: RTL and testbench

CONV_WINDOW_SCHEDULER -- requirements
Module: conv_window_scheduler

---
 rtl/conv_window_scheduler.sv | 166 ++++++++++++++++
 tb/tb_conv_window_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_scheduler.sv
// Convolution window scheduler: walks the top-left corner of a k x k window across a
// square input map, driving a downstream address generator and handing each window off.
module conv_window_scheduler #(
    parameter  int unsigned BUF_DEPTH  = 64,
    localparam int unsigned ADDR_WIDTH = $clog2(BUF_DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_k_size,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic                  i_ag_done,
    input  logic                  i_stall,
    input  logic                  i_out_ready,
    output logic                  o_ag_clear,
    output logic                  o_ag_en,
    output logic [ADDR_WIDTH-1:0] o_o_x,
    output logic [ADDR_WIDTH-1:0] o_o_y,
    output logic [ADDR_WIDTH-1:0] o_k_num,
    output logic                  o_win_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_RUN     = 3'd2,
        S_HANDOFF = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] i_size_q, i_size_d;
    logic [ADDR_WIDTH-1:0] k_size_q, k_size_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] x_q, x_d;
    logic [ADDR_WIDTH-1:0] y_q, y_d;
    logic [ADDR_WIDTH-1:0] k_num_q, k_num_d;
    logic                  ag_clear_q, ag_clear_d;
    logic                  ag_en_q, ag_en_d;
    logic                  win_valid_q, win_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic [CW-1:0]         nx, ny;
    logic                  last_win;
    logic                  cfg_illegal;

    // Next window position (column-inner) and whether the current one is the last.
    always_comb begin
        ny = CW'(y_q) + CW'(stride_q);
        nx = CW'(x_q);
        if ((ny + CW'(k_size_q)) > CW'(i_size_q)) begin
            ny = '0;
            nx = CW'(x_q) + CW'(stride_q);
        end
        last_win    = (nx + CW'(k_size_q)) > CW'(i_size_q);
        cfg_illegal = (i_k_size == '0) || (i_stride == '0) || (i_k_size > i_i_size);
    end

    always_comb begin
        state_d  = state_q;
        i_size_d = i_size_q;
        k_size_d = k_size_q;
        stride_d = stride_q;
        x_d      = x_q;
        y_d      = y_q;
        k_num_d  = k_num_q;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    i_size_d = i_i_size;
                    k_size_d = i_k_size;
                    stride_d = i_stride;
                    k_num_d  = ADDR_WIDTH'(i_k_size * i_k_size);
                    x_d      = '0;
                    y_d      = '0;
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    if (cfg_illegal) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: state_d = S_RUN;
            S_RUN: begin
                if (i_ag_done) state_d = S_HANDOFF;
            end
            S_HANDOFF: begin
                if (i_out_ready) begin
                    // The last window keeps its coordinates visible in DONE.
                    if (last_win) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_CLEAR;
                        x_d     = ADDR_WIDTH'(nx);
                        y_d     = ADDR_WIDTH'(ny);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ag_clear_d  = (state_d == S_CLEAR);
        ag_en_d     = (state_d == S_RUN) && !i_stall;
        win_valid_d = (state_d == S_HANDOFF);
        busy_d      = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_HANDOFF);
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            i_size_q    <= '0;
            k_size_q    <= '0;
            stride_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            k_num_q     <= '0;
            ag_clear_q  <= 1'b0;
            ag_en_q     <= 1'b0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_size_q    <= i_size_d;
            k_size_q    <= k_size_d;
            stride_q    <= stride_d;
            x_q         <= x_d;
            y_q         <= y_d;
            k_num_q     <= k_num_d;
            ag_clear_q  <= ag_clear_d;
            ag_en_q     <= ag_en_d;
            win_valid_q <= win_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign o_ag_clear  = ag_clear_q;
    assign o_ag_en     = ag_en_q;
    assign o_o_x       = x_q;
    assign o_o_y       = y_q;
    assign o_k_num     = k_num_q;
    assign o_win_valid = win_valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_conv_window_scheduler.sv
// Scoreboard bench for conv_window_scheduler: expected windows are queued at start,
// a negedge monitor pops and compares on every accepted handoff.
module tb_conv_window_scheduler;

    localparam int AW = 6;

    typedef struct packed {
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        logic [AW-1:0] k;
    } win_t;

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_i_size = '0;
    logic [AW-1:0] i_k_size = '0;
    logic [AW-1:0] i_stride = '0;
    logic          i_ag_done = 1'b0;
    logic          i_stall = 1'b0;
    logic          i_out_ready = 1'b1;
    logic          o_ag_clear, o_ag_en, o_win_valid, o_busy, o_done, o_err;
    logic [AW-1:0] o_o_x, o_o_y, o_k_num;

    int   checks = 0;
    int   failures = 0;
    int   clr_cnt = 0;
    int   en_cnt = 0;
    int   ag_cnt = 0;
    win_t exp_q[$];

    conv_window_scheduler #(.BUF_DEPTH(64)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start),
        .i_i_size(i_i_size), .i_k_size(i_k_size), .i_stride(i_stride),
        .i_ag_done(i_ag_done), .i_stall(i_stall), .i_out_ready(i_out_ready),
        .o_ag_clear(o_ag_clear), .o_ag_en(o_ag_en), .o_o_x(o_o_x), .o_o_y(o_o_y),
        .o_k_num(o_k_num), .o_win_valid(o_win_valid), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({o_ag_clear, o_ag_en, o_o_x, o_o_y, o_k_num, o_win_valid, o_busy, o_done, o_err});
    endfunction

    // Address-generator model: reports done after four enabled cycles.
    always @(negedge i_clk) begin
        if (!i_nrst) begin
            ag_cnt    = 0;
            i_ag_done = 1'b0;
        end else begin
            i_ag_done = 1'b0;
            if (o_ag_clear) ag_cnt = 0;
            else if (o_ag_en) begin
                ag_cnt++;
                if (ag_cnt >= 4) i_ag_done = 1'b1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (o_ag_clear) clr_cnt++;
        if (o_ag_en) en_cnt++;
    end

    // Scoreboard monitor: one pop per accepted handoff.
    always @(negedge i_clk) begin
        win_t e;
        if (i_nrst && o_win_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected window", 32'({o_o_x, o_o_y}), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("window x/y/k_num", 32'({o_o_x, o_o_y, o_k_num}), 32'(e));
            end
        end
    end

    task automatic push(input int x, input int y, input int k);
        win_t w;
        w.x = AW'(x);
        w.y = AW'(y);
        w.k = AW'(k);
        exp_q.push_back(w);
    endtask

    task automatic do_start(input int isz, input int ksz, input int str);
        @(posedge i_clk); #1;
        i_i_size = AW'(isz);
        i_k_size = AW'(ksz);
        i_stride = AW'(str);
        i_start  = 1'b1;
        @(posedge i_clk); #1;
        i_start  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic wait_sig(input string name, input bit want_valid);
        bit seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_clk);
            if (want_valid ? o_win_valid : o_ag_en) begin
                seen = 1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, e0, low;
        logic [AW-1:0] hx, hy;
        bit stable;

        // Reset state
        #13;
        check("reset outputs", all_outs(), 32'd0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        @(negedge i_clk);
        check("idle outputs", all_outs(), 32'd0);

        // 4x4 map, k=3, stride 1, with a start while busy that must be ignored
        push(0, 0, 9); push(0, 1, 9); push(1, 0, 9); push(1, 1, 9);
        c0 = clr_cnt;
        do_start(4, 3, 1);
        @(negedge i_clk);
        check("t1 busy/done after start", 32'({o_busy, o_done, o_ag_clear}), 32'b101);
        @(posedge i_clk); #1;
        i_i_size = 6'd10; i_k_size = 6'd2; i_stride = 6'd1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        wait_done("t1 done");
        check("t1 final state", 32'({o_busy, o_err, o_o_x, o_o_y}), 32'({1'b0, 1'b0, 6'd1, 6'd1}));
        check("t1 queue drained", 32'(exp_q.size()), 32'd0);
        check("t1 clear pulses", 32'(clr_cnt - c0), 32'd4);
        repeat (3) @(negedge i_clk);
        check("t1 done held", 32'({o_done, o_busy}), 32'b10);

        // 5x5 map, k=3, stride 2, consumer holds off 5 cycles per window
        push(0, 0, 9); push(0, 2, 9); push(2, 0, 9); push(2, 2, 9);
        c0 = clr_cnt;
        i_out_ready = 1'b0;
        do_start(5, 3, 2);
        for (int w = 0; w < 4; w++) begin
            wait_sig("t2 window valid", 1'b1);
            hx = o_o_x;
            hy = o_o_y;
            stable = 1;
            repeat (5) begin
                @(negedge i_clk);
                if (!o_win_valid || o_o_x != hx || o_o_y != hy) stable = 0;
            end
            check("t2 handoff hold", 32'(stable), 32'd1);
            @(posedge i_clk); #1;
            i_out_ready = 1'b1;
            @(posedge i_clk); #1;
            i_out_ready = 1'b0;
        end
        i_out_ready = 1'b1;
        wait_done("t2 done");
        check("t2 queue drained", 32'(exp_q.size()), 32'd0);
        check("t2 clear pulses", 32'(clr_cnt - c0), 32'd4);
        check("t2 final coords", 32'({o_o_x, o_o_y, o_err}), 32'({6'd2, 6'd2, 1'b0}));

        // Illegal configurations: k=0, stride=0, k>i_size
        for (int t = 0; t < 3; t++) begin
            c0 = clr_cnt;
            e0 = en_cnt;
            case (t)
                0:       do_start(4, 0, 1);
                1:       do_start(4, 3, 0);
                default: do_start(3, 4, 1);
            endcase
            @(negedge i_clk);
            check("err done/err/busy", 32'({o_done, o_err, o_busy}), 32'b110);
            repeat (4) @(negedge i_clk);
            check("err no clear/en", 32'((clr_cnt - c0) + (en_cnt - e0)), 32'd0);
        end

        // Three-cycle stall mid-RUN; window sequence unchanged
        push(0, 0, 9); push(0, 1, 9); push(1, 0, 9); push(1, 1, 9);
        do_start(4, 3, 1);
        check("t4 err cleared", 32'({o_err, o_done}), 32'b00);
        wait_sig("t4 enable seen", 1'b0);
        low = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge i_clk); #1;
            i_stall = (i < 3);
            @(negedge i_clk);
            if (!o_ag_en) low++;
        end
        i_stall = 1'b0;
        check("t4 stall low cycles", 32'(low), 32'd3);
        wait_done("t4 done");
        check("t4 queue drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset mid-RUN, then a single-window layer
        do_start(4, 3, 1);
        wait_sig("t6 enable seen", 1'b0);
        #2;
        i_nrst = 1'b0;
        exp_q.delete();
        #1;
        check("t6 async reset outputs", all_outs(), 32'd0);
        @(negedge i_clk);
        i_nrst = 1'b1;
        repeat (3) @(negedge i_clk);
        check("t6 idle after reset", 32'({o_done, o_busy, o_ag_en}), 32'd0);
        push(0, 0, 9);
        do_start(3, 3, 1);
        wait_done("t6 done");
        check("t6 queue drained", 32'(exp_q.size()), 32'd0);
        check("t6 final coords", 32'({o_o_x, o_o_y, o_k_num}), 32'({6'd0, 6'd0, 6'd9}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
